// File: rtl/lcd_msg_pkg.sv
// Shared message codes and scheduler state type for the LCD message scheduler.
package lcd_msg_pkg;

  localparam logic [3:0] WELCOME = 4'h0;
  localparam logic [3:0] IDEN    = 4'h1;
  localparam logic [3:0] PWRD    = 4'h2;
  localparam logic [3:0] OPTIONS = 4'h3;
  localparam logic [3:0] GAME    = 4'h4;
  localparam logic [3:0] SCORES  = 4'h5;
  localparam logic [3:0] TEAM    = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    SHOW_MIN,
    SHOW,
    LINGER
  } state_e;

endpackage

// File: rtl/lcd_tick_gen.sv
// Free-running prescaler producing a one-cycle dwell tick every CLK_DIV clocks.
module lcd_tick_gen
  import lcd_msg_pkg::*;
#(
  parameter int CLK_DIV = 60000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] cnt_q;
  logic          wrap;

  assign wrap   = (cnt_q == DW'(CLK_DIV - 1));
  assign tick_o = wrap;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (wrap) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DW'(1);
    end
  end

endmodule

// File: rtl/lcd_msg_scheduler.sv
// Shares one LCD among NREQ requesters with protected dwell, preemption and idle banner fallback.
// Build option: define LCD_SCHED_RR_EN for round-robin arbitration; fixed priority otherwise.
module lcd_msg_scheduler
  import lcd_msg_pkg::*;
#(
  parameter int         NREQ         = 4,
  parameter int         CLK_DIV      = 60000,
  parameter int         MIN_HOLD     = 800,
  parameter int         IDLE_TIMEOUT = 4000,
  parameter logic [3:0] DEFAULT_CODE = TEAM
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NREQ-1:0]     REQ,
  input  logic [4*NREQ-1:0]   REQ_CODE,
  output logic [NREQ-1:0]     GNT,
  output logic [3:0]          LCD_CHAR_ARRAY,
  output logic                SWITCH,
  output logic                BUSY
);

  localparam int MAX_COUNT = (MIN_HOLD > IDLE_TIMEOUT) ? MIN_HOLD : IDLE_TIMEOUT;
  localparam int CW        = $clog2(MAX_COUNT + 1);
  localparam int IW        = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [3:0]      code_q, code_d;
  logic            switch_q, busy_q;
  logic [CW-1:0]   dwell_q, dwell_d;
  logic [CW-1:0]   linger_q, linger_d;

  logic            tick;
  logic [3:0]      reqCode [NREQ];
  logic [3:0]      ownerCode;
  logic            ownerReq;
  logic            codeChanged;
  logic [NREQ-1:0] others;
  logic [NREQ-1:0] cand;
  logic [IW-1:0]   winIdx;
  logic [3:0]      winCode;
  logic            doGrant, doTrack, doDefault;
  logic            dwellDone, lingerDone;

  lcd_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk_i  (CLK),
    .rst_i  (RST),
    .tick_o (tick)
  );

  for (genvar g = 0; g < NREQ; g++) begin : g_code
    assign reqCode[g] = REQ_CODE[4*g +: 4];
  end

  always_comb begin
    ownerCode = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[IW'(i)]) ownerCode = ownerCode | reqCode[IW'(i)];
    end
  end

  assign ownerReq    = |(REQ & gnt_q);
  assign others      = REQ & ~gnt_q;
  assign codeChanged = ownerReq && (ownerCode != code_q);
  assign dwellDone   = (dwell_q >= CW'(MIN_HOLD));
  assign lingerDone  = (linger_q >= CW'(IDLE_TIMEOUT));

`ifdef LCD_SCHED_RR_EN
  logic [IW-1:0] ptr_q;

  // Scan backwards so the last hit is the first candidate after the previous grantee.
  always_comb begin
    winIdx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (cand[IW'((int'(ptr_q) + 1 + k) % NREQ)]) winIdx = IW'((int'(ptr_q) + 1 + k) % NREQ);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_q <= IW'(NREQ - 1);
    end else if (doGrant) begin
      ptr_q <= winIdx;
    end
  end
`else
  always_comb begin
    winIdx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (cand[IW'(k)]) winIdx = IW'(k);
    end
  end
`endif

  assign winCode = reqCode[winIdx];

  always_comb begin
    state_d   = state_q;
    cand      = '0;
    doGrant   = 1'b0;
    doTrack   = 1'b0;
    doDefault = 1'b0;
    case (state_q)
      IDLE: begin
        if (|REQ) begin
          cand    = REQ;
          doGrant = 1'b1;
          state_d = SHOW_MIN;
        end
      end
      SHOW_MIN: begin
        // A retargeted owner code restarts protection before expiry is considered.
        if (codeChanged) begin
          doTrack = 1'b1;
        end else if (dwellDone) begin
          if (|others) begin
            cand    = others;
            doGrant = 1'b1;
          end else if (ownerReq) begin
            state_d = SHOW;
          end else begin
            state_d = LINGER;
          end
        end
      end
      SHOW: begin
        if (|others) begin
          cand    = others;
          doGrant = 1'b1;
          state_d = SHOW_MIN;
        end else if (!ownerReq) begin
          state_d = LINGER;
        end else if (codeChanged) begin
          doTrack = 1'b1;
          state_d = SHOW_MIN;
        end
      end
      LINGER: begin
        if (|REQ) begin
          cand    = REQ;
          doGrant = 1'b1;
          state_d = SHOW_MIN;
        end else if (lingerDone) begin
          doDefault = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d    = gnt_q;
    code_d   = code_q;
    dwell_d  = (tick && (dwell_q != '1)) ? dwell_q + CW'(1) : dwell_q;
    linger_d = (tick && (linger_q != '1)) ? linger_q + CW'(1) : linger_q;
    if (doGrant) begin
      gnt_d         = '0;
      gnt_d[winIdx] = 1'b1;
      code_d        = winCode;
      dwell_d       = '0;
    end
    if (doTrack) begin
      code_d  = ownerCode;
      dwell_d = '0;
    end
    if ((state_d == LINGER) && (state_q != LINGER)) begin
      gnt_d    = '0;
      linger_d = '0;
    end
    if (doDefault) code_d = DEFAULT_CODE;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      code_q   <= DEFAULT_CODE;
      switch_q <= 1'b0;
      busy_q   <= 1'b0;
      dwell_q  <= '0;
      linger_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      code_q   <= code_d;
      switch_q <= (code_d != code_q);
      busy_q   <= (state_d == SHOW_MIN) || (state_d == SHOW);
      dwell_q  <= dwell_d;
      linger_q <= linger_d;
    end
  end

  assign GNT            = gnt_q;
  assign LCD_CHAR_ARRAY = code_q;
  assign SWITCH         = switch_q;
  assign BUSY           = busy_q;

endmodule

// File: tb/tb_lcd_msg_scheduler.sv
// Testbench for lcd_msg_scheduler: rule-level reference model plus directed and random stimulus.
// Honours LCD_SCHED_RR_EN to select the expected arbitration order.
module tb_lcd_msg_scheduler;

  localparam int         NREQ         = 4;
  localparam int         CLK_DIV      = 3;
  localparam int         MIN_HOLD     = 4;
  localparam int         IDLE_TIMEOUT = 6;
  localparam logic [3:0] DEF          = 4'hF;

  localparam int PH_IDLE = 0;
  localparam int PH_PROT = 1;
  localparam int PH_SHOW = 2;
  localparam int PH_LING = 3;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [NREQ-1:0]   REQ = '0;
  logic [4*NREQ-1:0] REQ_CODE = '0;
  logic [NREQ-1:0]   GNT;
  logic [3:0]        LCD_CHAR_ARRAY;
  logic              SWITCH;
  logic              BUSY;

  int   nChecks = 0;
  int   nPass   = 0;
  logic cmpEn   = 1'b0;

  int         mdlPhase, mdlOwner, mdlLast, mdlDwell, mdlLinger, mdlCyc;
  logic [3:0] mdlCode;
  logic [3:0] exGnt, exCode;
  logic       exSwitch, exBusy;

  lcd_msg_scheduler #(
    .NREQ         (NREQ),
    .CLK_DIV      (CLK_DIV),
    .MIN_HOLD     (MIN_HOLD),
    .IDLE_TIMEOUT (IDLE_TIMEOUT),
    .DEFAULT_CODE (DEF)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .REQ            (REQ),
    .REQ_CODE       (REQ_CODE),
    .GNT            (GNT),
    .LCD_CHAR_ARRAY (LCD_CHAR_ARRAY),
    .SWITCH         (SWITCH),
    .BUSY           (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] mkCodes(input logic [3:0] c0, input logic [3:0] c1,
                                          input logic [3:0] c2, input logic [3:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  function automatic int pickWinner(input logic [NREQ-1:0] mask);
`ifdef LCD_SCHED_RR_EN
    for (int k = 1; k <= NREQ; k++) begin
      if (mask[(mdlLast + k) % NREQ]) return (mdlLast + k) % NREQ;
    end
`else
    for (int i = 0; i < NREQ; i++) begin
      if (mask[i]) return i;
    end
`endif
    return -1;
  endfunction

  task automatic resetModel();
    mdlPhase  = PH_IDLE;
    mdlOwner  = -1;
    mdlLast   = NREQ - 1;
    mdlDwell  = 0;
    mdlLinger = 0;
    mdlCyc    = 0;
    mdlCode   = DEF;
    exGnt     = '0;
    exCode    = DEF;
    exSwitch  = 1'b0;
    exBusy    = 1'b0;
  endtask

  // One clock edge of the scheduling rules, evaluated on the inputs seen at that edge.
  task automatic modelStep();
    logic            tickNow;
    logic [3:0]      prev, ownCode;
    logic [NREQ-1:0] ownBit, oth;
    logic            ownReq;
    logic            rDwell, rLinger;
    int              w;
    tickNow = ((mdlCyc % CLK_DIV) == (CLK_DIV - 1));
    mdlCyc++;
    prev    = mdlCode;
    ownBit  = (mdlOwner >= 0) ? NREQ'(1 << mdlOwner) : '0;
    oth     = REQ & ~ownBit;
    ownReq  = (mdlOwner >= 0) && REQ[mdlOwner];
    ownCode = (mdlOwner >= 0) ? REQ_CODE[4*mdlOwner +: 4] : 4'h0;
    rDwell  = 1'b0;
    rLinger = 1'b0;
    w       = -1;
    case (mdlPhase)
      PH_IDLE: if (REQ != 0) w = pickWinner(REQ);
      PH_PROT: begin
        if (ownReq && ownCode != mdlCode) begin
          mdlCode = ownCode;
          rDwell  = 1'b1;
        end else if (mdlDwell >= MIN_HOLD) begin
          if (oth != 0) w = pickWinner(oth);
          else if (ownReq) mdlPhase = PH_SHOW;
          else begin
            mdlPhase = PH_LING;
            mdlOwner = -1;
            rLinger  = 1'b1;
          end
        end
      end
      PH_SHOW: begin
        if (oth != 0) w = pickWinner(oth);
        else if (!ownReq) begin
          mdlPhase = PH_LING;
          mdlOwner = -1;
          rLinger  = 1'b1;
        end else if (ownCode != mdlCode) begin
          mdlCode  = ownCode;
          rDwell   = 1'b1;
          mdlPhase = PH_PROT;
        end
      end
      default: begin
        if (REQ != 0) w = pickWinner(REQ);
        else if (mdlLinger >= IDLE_TIMEOUT) begin
          mdlCode  = DEF;
          mdlPhase = PH_IDLE;
        end
      end
    endcase
    if (w >= 0) begin
      mdlOwner = w;
      mdlLast  = w;
      mdlCode  = REQ_CODE[4*w +: 4];
      mdlPhase = PH_PROT;
      rDwell   = 1'b1;
    end
    mdlDwell  = rDwell ? 0 : ((tickNow && mdlDwell < MIN_HOLD) ? mdlDwell + 1 : mdlDwell);
    mdlLinger = rLinger ? 0 : ((tickNow && mdlLinger < IDLE_TIMEOUT) ? mdlLinger + 1 : mdlLinger);
    exGnt    = (mdlOwner >= 0) ? NREQ'(1 << mdlOwner) : '0;
    exCode   = mdlCode;
    exSwitch = (mdlCode != prev);
    exBusy   = (mdlPhase == PH_PROT) || (mdlPhase == PH_SHOW);
  endtask

  always @(posedge CLK or posedge RST) begin
    if (RST) resetModel();
    else modelStep();
  end

  always @(negedge CLK) begin
    if (!RST && cmpEn) begin
      checkOutput("GNT", 32'(GNT), 32'(exGnt));
      checkOutput("LCD_CHAR_ARRAY", 32'(LCD_CHAR_ARRAY), 32'(exCode));
      checkOutput("SWITCH", 32'(SWITCH), 32'(exSwitch));
      checkOutput("BUSY", 32'(BUSY), 32'(exBusy));
    end
  end

  task automatic applyStimulus(input logic [NREQ-1:0] req, input logic [4*NREQ-1:0] codes);
    @(negedge CLK);
    REQ      = req;
    REQ_CODE = codes;
  endtask

  task automatic resetDut();
    RST = 1'b1;
    REQ = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   d, lo, hi, pulses, nGrants;
    logic found, switchSeen, sawF;
    logic [NREQ-1:0] prevGnt;
    int   seq [5];
    int   expSeq [5];
`ifdef LCD_SCHED_RR_EN
    expSeq = '{0, 1, 2, 3, 0};
`else
    expSeq = '{0, 1, 0, 1, 0};
`endif

    resetDut();
    cmpEn = 1'b1;

    // Quiet period: banner stays up, nothing pulses.
    switchSeen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge CLK);
      if (SWITCH) switchSeen = 1'b1;
    end
    checkOutput("idleLcd", 32'(LCD_CHAR_ARRAY), 32'hF);
    checkOutput("idleGnt", 32'(GNT), 32'h0);
    checkOutput("idleBusy", 32'(BUSY), 32'h0);
    checkOutput("idleNoSwitch", 32'(switchSeen), 32'h0);

    // Single grant, one-cycle latency.
    applyStimulus(4'b0100, mkCodes(4'h0, 4'h0, 4'h3, 4'h0));
    @(negedge CLK);
    checkOutput("grantGnt", 32'(GNT), 32'h4);
    checkOutput("grantLcd", 32'(LCD_CHAR_ARRAY), 32'h3);
    checkOutput("grantSwitch", 32'(SWITCH), 32'h1);

    // Higher-priority request during protection waits for dwell expiry.
    found = 1'b0;
    d = 0;
    for (int c = 1; c <= 60 && !found; c++) begin
      @(negedge CLK);
      d = c;
      if (c == 1) begin
        checkOutput("switchOneShot", 32'(SWITCH), 32'h0);
        REQ      = 4'b0101;
        REQ_CODE = mkCodes(4'h4, 4'h0, 4'h3, 4'h0);
      end
      if (GNT != 4'b0100) found = 1'b1;
    end
    lo = MIN_HOLD * CLK_DIV - 1;
    hi = MIN_HOLD * CLK_DIV + 1;
    checkOutput("preemptSeen", 32'(found), 32'h1);
    checkOutput("preemptGnt", 32'(GNT), 32'h1);
    checkOutput("preemptLcd", 32'(LCD_CHAR_ARRAY), 32'h4);
    checkOutput("holdLenInWindow", 32'(d >= lo && d <= hi), 32'h1);

    // Owner releases: code lingers, then banner returns with one pulse.
    REQ = '0;
    found  = 1'b0;
    pulses = 0;
    d      = -1;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge CLK);
      if (d < 0 && GNT == '0) begin
        d = 0;
        checkOutput("lingerHoldsCode", 32'(LCD_CHAR_ARRAY), 32'h4);
      end else if (d >= 0) begin
        d++;
        if (SWITCH) pulses++;
        if (LCD_CHAR_ARRAY == 4'hF) found = 1'b1;
      end
    end
    lo = IDLE_TIMEOUT * CLK_DIV - 1;
    hi = IDLE_TIMEOUT * CLK_DIV + 1;
    checkOutput("bannerReturned", 32'(found), 32'h1);
    checkOutput("bannerPulses", 32'(pulses), 32'h1);
    checkOutput("lingerLenInWindow", 32'(d >= lo && d <= hi), 32'h1);

    // Request landing on the timeout cycle wins over the banner.
    applyStimulus(4'b1000, mkCodes(4'h0, 4'h0, 4'h0, 4'h2));
    applyStimulus(4'b0000, mkCodes(4'h0, 4'h0, 4'h0, 4'h2));
    found = 1'b0;
    sawF  = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge CLK);
      if (LCD_CHAR_ARRAY == 4'hF) sawF = 1'b1;
      if (mdlPhase == PH_LING && mdlLinger >= IDLE_TIMEOUT) begin
        REQ      = 4'b0010;
        REQ_CODE = mkCodes(4'h0, 4'h5, 4'h0, 4'h2);
        found    = 1'b1;
      end
    end
    checkOutput("timeoutEdgeReached", 32'(found), 32'h1);
    @(negedge CLK);
    if (LCD_CHAR_ARRAY == 4'hF) sawF = 1'b1;
    checkOutput("raceLcd", 32'(LCD_CHAR_ARRAY), 32'h5);
    checkOutput("raceGnt", 32'(GNT), 32'h2);
    checkOutput("raceNoBanner", 32'(sawF), 32'h0);

    // All requesters held: grant order per arbitration mode.
    resetDut();
    REQ      = 4'b1111;
    REQ_CODE = mkCodes(4'h1, 4'h2, 4'h3, 4'h6);
    prevGnt  = '0;
    nGrants  = 0;
    for (int c = 0; c < 300 && nGrants < 5; c++) begin
      @(negedge CLK);
      if (GNT != prevGnt && GNT != '0) begin
        for (int i = 0; i < NREQ; i++) if (GNT[i]) seq[nGrants] = i;
        nGrants++;
      end
      prevGnt = GNT;
    end
    checkOutput("rotationCount", 32'(nGrants), 32'h5);
    for (int i = 0; i < 5; i++) begin
      if (i < nGrants) checkOutput($sformatf("rotation[%0d]", i), 32'(seq[i]), 32'(expSeq[i]));
    end

    // Asynchronous reset in the middle of SHOW.
    resetDut();
    REQ      = 4'b0001;
    REQ_CODE = mkCodes(4'h2, 4'h0, 4'h0, 4'h0);
    repeat (3 * MIN_HOLD * CLK_DIV) @(negedge CLK);
    checkOutput("preResetGnt", 32'(GNT), 32'h1);
    checkOutput("preResetBusy", 32'(BUSY), 32'h1);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    checkOutput("asyncRstGnt", 32'(GNT), 32'h0);
    checkOutput("asyncRstLcd", 32'(LCD_CHAR_ARRAY), 32'hF);
    checkOutput("asyncRstSwitch", 32'(SWITCH), 32'h0);
    checkOutput("asyncRstBusy", 32'(BUSY), 32'h0);
    @(negedge CLK);
    REQ = '0;
    RST = 1'b0;

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 2) == 0) REQ = '0;
        else begin
          for (int i = 0; i < NREQ; i++) REQ[i] = ($urandom_range(0, 9) < 4);
        end
      end
      if ($urandom_range(0, 31) == 0) begin
        REQ_CODE[4*$urandom_range(0, NREQ - 1) +: 4] = 4'($urandom_range(0, 15));
      end
    end

    @(negedge CLK);
    cmpEn = 1'b0;
    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/lcd_msg_scheduler.md
# lcd_msg_scheduler

Shares the single 16x2 character LCD among several requesting subsystems (login FSM, game engine, score table). Each requester asks for a 4-bit message code; the scheduler arbitrates, enforces a minimum on-screen dwell so messages stay readable, and falls back to the team-name banner after an idle timeout. Its `LCD_CHAR_ARRAY` output drives the LCD driver's message-select input directly.

## Interface
- `NREQ`, 4: number of requesters. Index 0 has the highest fixed priority.
- `CLK_DIV`, 60000: CLK cycles per dwell tick (24 MHz / 400 Hz).
- `MIN_HOLD`, 800: ticks a newly granted message is protected from preemption (2 s).
- `IDLE_TIMEOUT`, 4000: ticks a released message lingers before the default banner returns (10 s).
- `DEFAULT_CODE`, 4'hF: message code shown when idle (team name).

Ports:
- `CLK`  in  1  system clock.
- `RST`  in  1  reset. Asynchronous, active-high.
- `REQ`  in  NREQ  level request per requester.
- `REQ_CODE`  in  4*NREQ  message code per requester. Slice i is `[4i+3:4i]`.
- `GNT`  out  NREQ  one-hot current owner. All zeros when no owner.
- `LCD_CHAR_ARRAY`  out  4  selected message code to the LCD driver.
- `SWITCH`  out  1  one-cycle pulse whenever `LCD_CHAR_ARRAY` changes value.
- `BUSY`  out  1  high in SHOW_MIN and SHOW.

## Operation
- Reset values: `GNT`=0, `LCD_CHAR_ARRAY`=`DEFAULT_CODE`, `SWITCH`=0, `BUSY`=0. State is IDLE, all counters are 0.
- Tick: a single-cycle pulse every `CLK_DIV` cycles. The dwell and linger counters advance only on a tick.
- Dwell and linger counter width is `$clog2(max(MIN_HOLD,IDLE_TIMEOUT)+1)`. Counters saturate and never wrap.
- Arbitration picks a winner from a candidate set:
  - Default: the lowest asserted index wins.
  - Grant action: registers the one-hot winner in `GNT`, loads the winner's `REQ_CODE` into `LCD_CHAR_ARRAY`, clears dwell, and enters SHOW_MIN.
- IDLE: if any `REQ` is high, arbitrate over all requesters.
- SHOW_MIN: no preemption.
  - If the owner changes its `REQ_CODE` while `REQ` is high, the new code is loaded and dwell restarts.
  - When dwell reaches `MIN_HOLD`, check in order:
    - Another requester is active: arbitrate over the non-owners.
    - The owner's `REQ` is high: go to SHOW.
    - Otherwise: go to LINGER.
- SHOW:
  - If any non-owner `REQ` is high, arbitrate over the non-owners (preemption).
  - Otherwise, if the owner's `REQ` drops, go to LINGER.
  - Owner code changes are tracked as in SHOW_MIN.
- LINGER: `GNT`=0 and the code is retained.
  - Any `REQ` high: arbitrate over all requesters.
  - Linger count reaches `IDLE_TIMEOUT`: load `DEFAULT_CODE` and go to IDLE.
- Simultaneous events:
  - A request in the same cycle as the timeout wins; the default banner is not shown.
  - A request in the same cycle as dwell expiry is handled by the SHOW_MIN order above.
- `SWITCH` pulses only on an actual value change. Re-granting the same code to a different requester updates `GNT` but does not pulse `SWITCH`.
- Reset asserted mid-operation forces the reset values asynchronously. After `RST` deasserts, the tick prescaler restarts from 0.

## Timing
- `REQ` sampled high at edge N: `GNT` and `LCD_CHAR_ARRAY` update at edge N+1, with `SWITCH` high for the cycle after N+1. Latency is one cycle.
- Minimum display time is `MIN_HOLD` ticks, within one tick period of jitter, because the prescaler free-runs.
- All outputs are registered. There are no combinational paths from input to output.

## Configuration
- `LCD_SCHED_RR_EN`:
  - Defined: round-robin arbitration. A pointer holds the last grantee, and the search starts at pointer+1 (mod `NREQ`). The pointer resets to `NREQ-1`, so the first search starts at index 0.
  - Undefined: fixed priority, lowest index wins.
  - All other behaviour is identical in both builds.

## Structure
- Package `lcd_msg_pkg` holds the message-code constants: WELCOME=0, IDEN=1, PWRD=2, OPTIONS=3, GAME=4, SCORES=5, TEAM=4'hF. It also holds the state enum: IDLE, SHOW_MIN, SHOW, LINGER.
- Sub-module `lcd_tick_gen` is the free-running `CLK_DIV` prescaler with a one-cycle tick output.

## Test plan
- Reset, then `REQ`=0 for 5 s of simulated time: outputs remain `LCD_CHAR_ARRAY`=F, `GNT`=0, `BUSY`=0, and `SWITCH` never pulses.
- `REQ[2]`=1 with code 3: one cycle later, `GNT`=4'b0100, `LCD_CHAR_ARRAY`=3, and `SWITCH` pulses once.
- Owner is req 2 in SHOW_MIN. Raise `REQ[0]` (code 4) at tick 100: no change until tick 800, then `GNT`=4'b0001 and code=4.
- Owner drops `REQ` after 900 ticks with no other requests: code is held for 4000 ticks, then returns to F with one `SWITCH` pulse. Repeat with `REQ[1]` raised exactly on the timeout cycle: code goes straight to req 1's code, and F never appears.
- With `LCD_SCHED_RR_EN` defined, hold all four `REQ` high: grants rotate 0→1→2→3→0, one per `MIN_HOLD` interval. Without the macro, the same stimulus gives grants alternating 0→1→0.
- Assert `RST` mid-SHOW: all outputs reach their reset values without waiting for a `CLK` edge.
